// File: rtl/memory_queue.sv
// In-order load/store queue: allocates ops in program order, snoops result buses
// for missing operands, issues oldest-first to the memory port, retires from the head.
module memory_queue #(
  parameter int SIZE               = 32,
  parameter int DEPTH              = 4,
  parameter int STATION_INDEX_SIZE = 1,
  parameter int BUS_COUNT          = 1
) (
  input  logic                                            clock,
  input  logic                                            reset,
  input  logic                                            flush,
  input  logic                                            alloc_valid,
  output logic                                            alloc_ready,
  input  logic                                            alloc_operation,
  input  logic [1:0]                                      alloc_data_size,
  input  logic                                            alloc_is_signed,
  input  logic                                            alloc_preload_address,
  input  logic [STATION_INDEX_SIZE-1:0]                   alloc_address_source,
  input  logic [SIZE-1:0]                                 alloc_preloaded_address,
  input  logic [SIZE-1:0]                                 alloc_address_offset,
  input  logic                                            alloc_preload_data,
  input  logic [STATION_INDEX_SIZE-1:0]                   alloc_data_source,
  input  logic [SIZE-1:0]                                 alloc_preloaded_data,
  input  logic [BUS_COUNT-1:0]                            bus_asserted,
  input  logic [BUS_COUNT-1:0][STATION_INDEX_SIZE-1:0]    bus_source,
  input  logic [BUS_COUNT-1:0][SIZE-1:0]                  bus_value,
  output logic                                            result_valid,
  output logic [SIZE-1:0]                                 result,
  input  logic                                            result_ack,
  output logic                                            memory_enable,
  output logic                                            memory_operation,
  input  logic                                            memory_ready,
  output logic [1:0]                                      memory_data_size,
  output logic [SIZE-1:0]                                 memory_address,
  input  logic [SIZE-1:0]                                 memory_data_in,
  output logic [SIZE-1:0]                                 memory_data_out
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  typedef logic [STATION_INDEX_SIZE-1:0] tag_t;

  // Control state (reset)
  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_performed;
  logic [DEPTH-1:0] r_addr_loaded;
  logic [DEPTH-1:0] r_data_loaded;
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [PW-1:0]    r_issue;
  logic [PW:0]      r_count;

  // Payload (not reset)
  logic [DEPTH-1:0] r_operation;
  logic [DEPTH-1:0] r_is_signed;
  logic [1:0]       r_data_size      [DEPTH];
  tag_t             r_address_source [DEPTH];
  tag_t             r_data_source    [DEPTH];
  logic [SIZE-1:0]  r_address_base   [DEPTH];
  logic [SIZE-1:0]  r_address_offset [DEPTH];
  logic [SIZE-1:0]  r_store_data     [DEPTH];
  logic [SIZE-1:0]  r_load_data      [DEPTH];

  logic             w_alloc;
  logic             w_complete;
  logic             w_retire;
  logic [SIZE:0]    w_alloc_addr_snoop;
  logic [SIZE:0]    w_alloc_data_snoop;
  logic [SIZE:0]    w_addr_snoop [DEPTH];
  logic [SIZE:0]    w_data_snoop [DEPTH];

  // Returns {hit, value}; the lowest-index matching bus wins.
  function automatic logic [SIZE:0] snoop(
    input tag_t                                         tag,
    input logic [BUS_COUNT-1:0]                         asserted,
    input logic [BUS_COUNT-1:0][STATION_INDEX_SIZE-1:0] source,
    input logic [BUS_COUNT-1:0][SIZE-1:0]               value
  );
    logic [SIZE:0] hit_val;
    hit_val = '0;
    for (int b = BUS_COUNT-1; b >= 0; b--) begin
      if (asserted[b] && (source[b] == tag)) hit_val = {1'b1, value[b]};
    end
    return hit_val;
  endfunction

  function automatic logic [SIZE-1:0] extend(
    input logic [SIZE-1:0] raw,
    input logic [1:0]      size,
    input logic            is_signed
  );
    logic [SIZE-1:0] ext;
    case (size)
      2'd0:    ext = is_signed ? SIZE'($signed(raw[7:0]))  : SIZE'(raw[7:0]);
      2'd1:    ext = is_signed ? SIZE'($signed(raw[15:0])) : SIZE'(raw[15:0]);
      2'd2:    ext = is_signed ? SIZE'($signed(raw[31:0])) : SIZE'(raw[31:0]);
      default: ext = '0;
    endcase
    return ext;
  endfunction

  always_comb begin
    w_alloc_addr_snoop = snoop(alloc_address_source, bus_asserted, bus_source, bus_value);
    w_alloc_data_snoop = snoop(alloc_data_source, bus_asserted, bus_source, bus_value);
    for (int i = 0; i < DEPTH; i++) begin
      w_addr_snoop[i] = snoop(r_address_source[i], bus_asserted, bus_source, bus_value);
      w_data_snoop[i] = snoop(r_data_source[i], bus_asserted, bus_source, bus_value);
    end
  end

  assign alloc_ready   = (r_count != FULL_COUNT);
  assign memory_enable = r_valid[r_issue] && r_addr_loaded[r_issue] &&
                         r_data_loaded[r_issue] && !r_performed[r_issue];
  assign result_valid  = r_valid[r_head] && r_performed[r_head];

  // Flush overrides every other state change in its cycle.
  assign w_alloc    = alloc_valid && alloc_ready && !flush;
  assign w_complete = memory_enable && memory_ready && !flush;
  assign w_retire   = result_valid && result_ack && !flush;

  assign memory_operation = r_operation[r_issue];
  assign memory_data_size = r_data_size[r_issue];
  assign memory_address   = r_address_base[r_issue] + r_address_offset[r_issue];
  assign memory_data_out  = r_store_data[r_issue];

  assign result = (result_valid && !r_operation[r_head]) ?
                  extend(r_load_data[r_head], r_data_size[r_head], r_is_signed[r_head]) : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valid       <= '0;
      r_performed   <= '0;
      r_addr_loaded <= '0;
      r_data_loaded <= '0;
      r_head        <= '0;
      r_tail        <= '0;
      r_issue       <= '0;
      r_count       <= '0;
    end else if (flush) begin
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_issue <= '0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_alloc && (r_tail == PW'(i))) begin
          r_addr_loaded[i] <= alloc_preload_address || w_alloc_addr_snoop[SIZE];
          r_data_loaded[i] <= alloc_preload_data || w_alloc_data_snoop[SIZE];
        end else begin
          if (!r_addr_loaded[i] && w_addr_snoop[i][SIZE]) r_addr_loaded[i] <= 1'b1;
          if (!r_data_loaded[i] && w_data_snoop[i][SIZE]) r_data_loaded[i] <= 1'b1;
        end
      end
      if (w_complete) begin
        r_performed[r_issue] <= 1'b1;
        r_issue              <= r_issue + 1'b1;
      end
      if (w_retire) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end
      if (w_alloc) begin
        r_valid[r_tail]     <= 1'b1;
        r_performed[r_tail] <= 1'b0;
        r_tail              <= r_tail + 1'b1;
      end
      r_count <= r_count + (PW+1)'(w_alloc) - (PW+1)'(w_retire);
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_alloc && (r_tail == PW'(i))) begin
        r_operation[i]      <= alloc_operation;
        r_data_size[i]      <= alloc_data_size;
        r_is_signed[i]      <= alloc_is_signed;
        r_address_source[i] <= alloc_address_source;
        r_data_source[i]    <= alloc_data_source;
        r_address_offset[i] <= alloc_address_offset;
        r_address_base[i]   <= alloc_preload_address ? alloc_preloaded_address
                                                     : w_alloc_addr_snoop[SIZE-1:0];
        r_store_data[i]     <= alloc_preload_data ? alloc_preloaded_data
                                                  : w_alloc_data_snoop[SIZE-1:0];
      end else begin
        if (!r_addr_loaded[i] && w_addr_snoop[i][SIZE]) r_address_base[i] <= w_addr_snoop[i][SIZE-1:0];
        if (!r_data_loaded[i] && w_data_snoop[i][SIZE]) r_store_data[i] <= w_data_snoop[i][SIZE-1:0];
      end
    end
    if (w_complete) r_load_data[r_issue] <= memory_data_in;
  end

endmodule

// File: tb/tb_memory_queue.sv
// Bench for memory_queue: directed scenarios followed by randomized traffic
// compared against a queue-based reference model.
module tb_memory_queue;

  localparam int SIZE = 32;
  localparam int DEPTH = 4;
  localparam int SIS = 2;
  localparam int BC = 2;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                      reset, flush;
  logic                      alloc_valid, alloc_ready, alloc_operation, alloc_is_signed;
  logic [1:0]                alloc_data_size;
  logic                      alloc_preload_address, alloc_preload_data;
  logic [SIS-1:0]            alloc_address_source, alloc_data_source;
  logic [SIZE-1:0]           alloc_preloaded_address, alloc_address_offset, alloc_preloaded_data;
  logic [BC-1:0]             bus_asserted;
  logic [BC-1:0][SIS-1:0]    bus_source;
  logic [BC-1:0][SIZE-1:0]   bus_value;
  logic                      result_valid, result_ack;
  logic [SIZE-1:0]           result;
  logic                      memory_enable, memory_operation, memory_ready;
  logic [1:0]                memory_data_size;
  logic [SIZE-1:0]           memory_address, memory_data_in, memory_data_out;

  memory_queue #(.SIZE(SIZE), .DEPTH(DEPTH), .STATION_INDEX_SIZE(SIS), .BUS_COUNT(BC)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_operation(alloc_operation), .alloc_data_size(alloc_data_size),
    .alloc_is_signed(alloc_is_signed), .alloc_preload_address(alloc_preload_address),
    .alloc_address_source(alloc_address_source), .alloc_preloaded_address(alloc_preloaded_address),
    .alloc_address_offset(alloc_address_offset), .alloc_preload_data(alloc_preload_data),
    .alloc_data_source(alloc_data_source), .alloc_preloaded_data(alloc_preloaded_data),
    .bus_asserted(bus_asserted), .bus_source(bus_source), .bus_value(bus_value),
    .result_valid(result_valid), .result(result), .result_ack(result_ack),
    .memory_enable(memory_enable), .memory_operation(memory_operation),
    .memory_ready(memory_ready), .memory_data_size(memory_data_size),
    .memory_address(memory_address), .memory_data_in(memory_data_in),
    .memory_data_out(memory_data_out)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit        op;
    bit [1:0]  sz;
    bit        sgn;
    bit        a_ok;
    bit [31:0] a_base;
    bit [31:0] a_off;
    bit [1:0]  a_tag;
    bit        d_ok;
    bit [31:0] d;
    bit [1:0]  d_tag;
    bit        done;
    bit [31:0] ld;
  } ent_t;

  ent_t mq[$];
  int   exp_issue;
  bit   exp_en;
  bit   exp_rv;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    flush = 0; alloc_valid = 0; alloc_operation = 0; alloc_data_size = 0; alloc_is_signed = 0;
    alloc_preload_address = 0; alloc_address_source = 0; alloc_preloaded_address = 0;
    alloc_address_offset = 0; alloc_preload_data = 0; alloc_data_source = 0;
    alloc_preloaded_data = 0; bus_asserted = 0; bus_source = '0; bus_value = '0;
    result_ack = 0; memory_ready = 0; memory_data_in = 0;
  endtask

  task automatic set_alloc(input bit op, input bit [1:0] sz, input bit sgn, input bit pa,
                           input bit [1:0] atag, input bit [31:0] abase, input bit [31:0] aoff,
                           input bit pd, input bit [1:0] dtag, input bit [31:0] d);
    alloc_valid = 1; alloc_operation = op; alloc_data_size = sz; alloc_is_signed = sgn;
    alloc_preload_address = pa; alloc_address_source = atag; alloc_preloaded_address = abase;
    alloc_address_offset = aoff; alloc_preload_data = pd; alloc_data_source = dtag;
    alloc_preloaded_data = d;
  endtask

  function automatic bit bus_hit(input logic [1:0] tag, output logic [31:0] v);
    v = 0;
    for (int b = 0; b < BC; b++) begin
      if (bus_asserted[b] && bus_source[b] == tag) begin
        v = bus_value[b];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic int issue_index();
    for (int i = 0; i < mq.size(); i++) if (!mq[i].done) return i;
    return -1;
  endfunction

  function automatic logic [31:0] model_ext(input ent_t e);
    logic [31:0] v;
    if (e.op || e.sz == 2'd3) return 32'h0;
    if (e.sz == 2'd0) begin
      v = e.ld & 32'hFF;
      if (e.sgn && v >= 32'h80) v = v | 32'hFFFFFF00;
    end else if (e.sz == 2'd1) begin
      v = e.ld & 32'hFFFF;
      if (e.sgn && v >= 32'h8000) v = v | 32'hFFFF0000;
    end else begin
      v = e.ld;
    end
    return v;
  endfunction

  // Advance the reference queue by one clock edge using the current inputs.
  task automatic model_step();
    ent_t        e;
    int          n, ii;
    bit          ret, comp, al;
    logic [31:0] v;
    if (flush) begin
      mq.delete();
      return;
    end
    n    = mq.size();
    ii   = issue_index();
    ret  = n > 0 && mq[0].done && result_ack;
    comp = ii >= 0 && mq[ii].a_ok && mq[ii].d_ok && memory_ready;
    al   = alloc_valid && n < DEPTH;
    for (int i = 0; i < n; i++) begin
      e = mq[i];
      if (comp && i == ii) begin
        e.done = 1;
        e.ld   = memory_data_in;
      end
      if (!e.a_ok && bus_hit(e.a_tag, v)) begin e.a_ok = 1; e.a_base = v; end
      if (!e.d_ok && bus_hit(e.d_tag, v)) begin e.d_ok = 1; e.d = v; end
      mq[i] = e;
    end
    if (ret) void'(mq.pop_front());
    if (al) begin
      e.op = alloc_operation; e.sz = alloc_data_size; e.sgn = alloc_is_signed;
      e.a_ok = alloc_preload_address; e.a_base = alloc_preloaded_address;
      e.a_off = alloc_address_offset; e.a_tag = alloc_address_source;
      e.d_ok = alloc_preload_data; e.d = alloc_preloaded_data; e.d_tag = alloc_data_source;
      e.done = 0; e.ld = 0;
      if (!e.a_ok && bus_hit(e.a_tag, v)) begin e.a_ok = 1; e.a_base = v; end
      if (!e.d_ok && bus_hit(e.d_tag, v)) begin e.d_ok = 1; e.d = v; end
      mq.push_back(e);
    end
  endtask

  initial begin
    idle_inputs();
    reset = 0;
    @(negedge clock);
    check("reset_alloc_ready", alloc_ready, 1);
    check("reset_result_valid", result_valid, 0);
    check("reset_mem_enable", memory_enable, 0);
    reset = 1;

    // Preloaded signed byte load
    set_alloc(0, 0, 1, 1, 0, 32'h100, 32'h4, 1, 0, 0);
    memory_ready = 1; memory_data_in = 32'hF0;
    tick(); alloc_valid = 0;
    check("ld_enable", memory_enable, 1);
    check("ld_address", memory_address, 32'h104);
    check("ld_operation", memory_operation, 0);
    check("ld_rv_early", result_valid, 0);
    tick();
    check("ld_result_valid", result_valid, 1);
    check("ld_result", result, 32'hFFFFFFF0);
    check("ld_enable_after", memory_enable, 0);
    result_ack = 1; tick(); result_ack = 0;
    check("ld_retired", result_valid, 0);
    check("ld_alloc_ready", alloc_ready, 1);

    // Store waiting on bus-delivered data
    memory_ready = 0;
    set_alloc(1, 2, 0, 1, 0, 32'h200, 0, 0, 1, 0);
    tick(); alloc_valid = 0;
    check("st_wait0", memory_enable, 0);
    tick();
    check("st_wait1", memory_enable, 0);
    bus_asserted = 2'b01; bus_source[0] = 1; bus_value[0] = 32'hDEADBEEF;
    tick(); bus_asserted = 0;
    check("st_enable", memory_enable, 1);
    check("st_data_out", memory_data_out, 32'hDEADBEEF);
    check("st_operation", memory_operation, 1);
    check("st_address", memory_address, 32'h200);
    memory_ready = 1; tick(); memory_ready = 0;
    check("st_result_valid", result_valid, 1);
    check("st_result", result, 0);
    result_ack = 1; tick(); result_ack = 0;

    // Fill to DEPTH, then retire+allocate while full
    for (int k = 0; k < 5; k++) begin
      set_alloc(0, 2, 0, 1, 0, 32'h10 * (k + 1), 0, 1, 0, 0);
      tick();
      check("full_alloc_ready", alloc_ready, (k < 3) ? 1 : 0);
    end
    alloc_valid = 0;
    check("full_hold_address", memory_address, 32'h10);
    memory_ready = 1; tick(); memory_ready = 0;
    check("full_head_done", result_valid, 1);
    check("full_next_enable", memory_enable, 1);
    check("full_next_address", memory_address, 32'h20);
    set_alloc(0, 2, 0, 1, 0, 32'h999, 0, 1, 0, 0);
    result_ack = 1; tick(); result_ack = 0; alloc_valid = 0;
    check("full_alloc_refused", alloc_ready, 1);
    check("full_hold_after_retire", memory_address, 32'h20);

    // Flush during a completing access
    memory_ready = 1; flush = 1; tick(); flush = 0; memory_ready = 0;
    check("flush_result_valid", result_valid, 0);
    check("flush_alloc_ready", alloc_ready, 1);
    check("flush_enable", memory_enable, 0);
    tick();
    check("flush_no_late_result", result_valid, 0);

    // Older entry blocks a ready younger entry
    memory_ready = 1; memory_data_in = 32'h80;
    set_alloc(0, 0, 0, 0, 2, 0, 0, 1, 0, 0);
    tick();
    check("order_stall0", memory_enable, 0);
    set_alloc(0, 1, 1, 1, 0, 32'h50, 0, 1, 0, 0);
    tick(); alloc_valid = 0;
    check("order_stall1", memory_enable, 0);
    tick();
    check("order_stall2", memory_enable, 0);
    bus_asserted = 2'b10; bus_source[1] = 2; bus_value[1] = 32'h40;
    tick(); bus_asserted = 0;
    check("order_first_enable", memory_enable, 1);
    check("order_first_address", memory_address, 32'h40);
    tick();
    check("order_second_enable", memory_enable, 1);
    check("order_second_address", memory_address, 32'h50);
    check("order_first_result", result, 32'h80);
    memory_data_in = 32'h9234;
    tick(); memory_ready = 0;
    check("order_head_still_first", result, 32'h80);
    result_ack = 1; tick();
    check("order_second_rv", result_valid, 1);
    check("order_second_result", result, 32'hFFFF9234);
    tick(); result_ack = 0;
    check("order_drained", result_valid, 0);

    // Bus priority and independent operand capture in the allocation cycle
    set_alloc(0, 2, 0, 0, 1, 0, 0, 1, 0, 0);
    bus_asserted = 2'b11; bus_source[0] = 1; bus_source[1] = 1;
    bus_value[0] = 32'h11; bus_value[1] = 32'h22;
    tick(); alloc_valid = 0; bus_asserted = 0;
    check("prio_enable", memory_enable, 1);
    check("prio_address", memory_address, 32'h11);
    memory_ready = 1; tick(); memory_ready = 0;
    result_ack = 1; tick(); result_ack = 0;
    set_alloc(1, 2, 0, 0, 2, 0, 32'h8, 0, 3, 0);
    bus_asserted = 2'b11; bus_source[0] = 2; bus_source[1] = 3;
    bus_value[0] = 32'h300; bus_value[1] = 32'hCAFE;
    tick(); alloc_valid = 0; bus_asserted = 0;
    check("indep_address", memory_address, 32'h308);
    check("indep_data", memory_data_out, 32'hCAFE);
    memory_ready = 1; tick(); memory_ready = 0;
    result_ack = 1; tick(); result_ack = 0;

    // Asynchronous reset mid-access
    set_alloc(0, 2, 0, 1, 0, 32'h700, 0, 1, 0, 0);
    tick(); alloc_valid = 0;
    check("areset_pre_enable", memory_enable, 1);
    #2 reset = 0;
    #1;
    check("areset_enable", memory_enable, 0);
    check("areset_alloc_ready", alloc_ready, 1);
    check("areset_result_valid", result_valid, 0);
    @(negedge clock); reset = 1;

    // Randomized traffic against the reference queue
    mq.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      exp_issue = issue_index();
      exp_en = exp_issue >= 0 && mq[exp_issue].a_ok && mq[exp_issue].d_ok;
      check("rnd_alloc_ready", alloc_ready, (mq.size() < DEPTH) ? 1 : 0);
      check("rnd_mem_enable", memory_enable, exp_en);
      if (exp_en) begin
        check("rnd_mem_op", memory_operation, mq[exp_issue].op);
        check("rnd_mem_size", memory_data_size, mq[exp_issue].sz);
        check("rnd_mem_address", memory_address, mq[exp_issue].a_base + mq[exp_issue].a_off);
        check("rnd_mem_data_out", memory_data_out, mq[exp_issue].d);
      end
      exp_rv = mq.size() > 0 && mq[0].done;
      check("rnd_result_valid", result_valid, exp_rv);
      if (exp_rv) check("rnd_result", result, model_ext(mq[0]));

      alloc_valid = ($urandom_range(0, 1) == 1);
      alloc_operation = $urandom_range(0, 1);
      alloc_data_size = 2'($urandom_range(0, 3));
      alloc_is_signed = $urandom_range(0, 1);
      alloc_preload_address = ($urandom_range(0, 4) < 3);
      alloc_address_source = 2'($urandom_range(0, 3));
      alloc_preloaded_address = $urandom;
      alloc_address_offset = $urandom;
      alloc_preload_data = alloc_operation ? ($urandom_range(0, 4) < 3) : 1'b1;
      alloc_data_source = 2'($urandom_range(0, 3));
      alloc_preloaded_data = $urandom;
      for (int b = 0; b < BC; b++) begin
        bus_asserted[b] = ($urandom_range(0, 4) < 2);
        bus_source[b] = 2'($urandom_range(0, 3));
        bus_value[b] = $urandom;
      end
      memory_ready = $urandom_range(0, 1);
      memory_data_in = $urandom;
      result_ack = $urandom_range(0, 1);
      flush = ($urandom_range(0, 49) == 0);
      model_step();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
